// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the RiScKy fetch sequencer.
package fetch_seq_pkg;
  localparam int              XLEN            = 32;
  localparam logic [XLEN-1:0] NOP             = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEF_RESET_VEC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VEC    = 32'h0000_0100;
  localparam int              DEF_ACK_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_HOLD
  } fetch_state_e;

  function automatic logic misaligned(input logic [XLEN-1:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter; expired_o fires on the MAX-th consecutive enabled cycle.
module fetch_timeout_ctr #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int          W    = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (en_i && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/fetch_seq.sv
// Front-end fetch sequencer: owns the PC, drives the imem req/ack port and a
// one-entry instruction register toward decode.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC   = DEF_RESET_VEC,
  parameter logic [XLEN-1:0] TRAP_VEC    = DEF_TRAP_VEC,
  parameter int              ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_i,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc,
  output logic            misalign_o,
  output logic            bus_err_o
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, fa_q, fa_d, instr_q, instr_d, ipc_q, ipc_d;
  logic            iv_q, iv_d, mis_q, mis_d, berr_q, berr_d;
  logic            flush, launch, tmo_en, tmo_clr, tmo_exp;
  logic [XLEN-1:0] flush_pc;

  assign flush    = trap_i | redirect_valid;
  assign flush_pc = (trap_i || misaligned(redirect_target)) ? TRAP_VEC : redirect_target;
  assign imem_req = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign tmo_en   = imem_req && !imem_ack;
  assign tmo_clr  = imem_ack || launch || (state_d != state_q);

  fetch_timeout_ctr #(.MAX(ACK_TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_exp)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fa_d    = fa_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    iv_d    = iv_q;
    berr_d  = 1'b0;
    mis_d   = redirect_valid && !trap_i && misaligned(redirect_target);
    launch  = 1'b0;
    if (flush) pc_d = flush_pc;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        launch  = 1'b1;
      end
      ST_FETCH, ST_DRAIN: begin
        if (tmo_exp) begin
          // abort the bus cycle; a one-cycle IDLE bubble precedes the trap fetch
          state_d = ST_IDLE;
          pc_d    = TRAP_VEC;
          berr_d  = 1'b1;
        end else if (imem_ack) begin
          if (state_q == ST_FETCH && !flush) begin
            instr_d = imem_rdata;
            ipc_d   = fa_q;
            iv_d    = 1'b1;
            pc_d    = fa_q + 32'd4;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_FETCH;
            launch  = 1'b1;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (flush || !stall_i) begin
          iv_d    = 1'b0;
          state_d = ST_FETCH;
          launch  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (launch) fa_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VEC;
      fa_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      iv_q    <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      iv_q    <= iv_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign imem_addr   = fa_q;
  assign instr_valid = iv_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign pc          = pc_q;
  assign misalign_o  = mis_q;
  assign bus_err_o   = berr_q;
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Fetch sequencer for the RiScKy core. It owns the program counter and decides the next PC each cycle: sequential +4, branch/jump redirect, or trap vector.
- It drives a req/ack instruction-memory port and hands fetched instructions to decode through a one-entry output register with stall backpressure.
- It is the single controller of PC update for the core's front end.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap, misaligned redirect, or bus timeout.
- ACK_TIMEOUT, 16, max cycles imem_req may wait for imem_ack before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- stall_i  in  1  decode cannot accept; holds the current instruction.
- redirect_valid  in  1  one-cycle branch/jump taken pulse.
- redirect_target  in  32  redirect destination.
- trap_i  in  1  one-cycle trap request.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  fetch address, stable while imem_req=1.
- imem_ack  in  1  read data valid; may arrive in the same cycle as req.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- pc  out  32  next address to fetch.
- misalign_o  out  1  one-cycle pulse: redirect target[1:0]!=0.
- bus_err_o  out  1  one-cycle pulse: ack timeout.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_VEC; state=IDLE.
  - imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, misalign_o=0, bus_err_o=0, timeout counter=0.
- States:
  - IDLE: no request. Moves to FETCH on the next clk after reset release or after an abort.
  - FETCH: imem_req=1, imem_addr=fetch_addr latched on entry (=pc). Output buffer is empty throughout.
  - DRAIN: imem_req=1 with old address; returned data is discarded.
  - HOLD: instr_valid=1, no request.
- Next-PC priority: trap_i > redirect_valid > sequential.
  - Trap target is TRAP_VEC.
  - Redirect target with [1:0]!=0 loads TRAP_VEC and pulses misalign_o.
- Transitions:
  - FETCH & ack & no flush: capture. instr<=imem_rdata, instr_pc<=fetch_addr, instr_valid<=1, pc<=fetch_addr+4. Go HOLD.
  - HOLD & !stall_i: instruction consumed. instr_valid<=0, fetch_addr<=pc. Go FETCH.
  - HOLD & stall_i: all outputs hold.
  - Flush in HOLD: instr_valid<=0, pc<=target. Go FETCH next cycle at the new pc.
  - Flush in FETCH, no ack: pc<=target. Go DRAIN; imem_addr unchanged.
  - Flush in FETCH with ack in the same cycle: data discarded, pc<=target. Re-enter FETCH with the new address.
  - DRAIN & ack: data discarded. Go FETCH at pc.
  - Flush in DRAIN: pc<=new target. Stay DRAIN.
- Timeout:
  - Counter increments each cycle in FETCH/DRAIN without ack, and clears on ack or state exit.
  - Reaching ACK_TIMEOUT: bus_err_o pulse, pc<=TRAP_VEC, req dropped. Go IDLE (one-cycle bubble), then FETCH.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No carry out.
- Throughput: peak one instruction per 2 cycles (zero-wait memory). There is no prefetch.
- Mid-operation reset abandons the outstanding request. imem_req falls immediately (async).

Decomposition:
- Shared package: state enum (IDLE, FETCH, DRAIN, HOLD), NOP encoding 32'h0000_0013, XLEN=32, default vectors.
- One sub-module: fetch_timeout_ctr, a parameterised saturating counter with clear, enable and expired output.
- The FSM and PC register stay in fetch_seq.

Test Plan:
- Reset then free-run, ack same cycle, stall_i=0 -> imem_addr 0,4,8,C on alternating cycles. instr_pc matches; instr_valid pulses every 2nd cycle.
- stall_i=1 for 5 cycles while HOLD at instr_pc=8 -> instr, instr_pc=8 and instr_valid stable. imem_req=0. Fetch of 0xC starts the cycle after stall_i falls.
- redirect_valid with target 0x200 while FETCH at 0x10, ack 3 cycles later -> DRAIN, imem_addr stays 0x10. Data dropped. Next request is 0x200; the 0x10 instr never appears.
- trap_i and redirect_valid(0x400) in the same cycle -> pc=TRAP_VEC (0x100), next fetch 0x100.
- redirect target 0x202 -> misalign_o=1 for one cycle, next fetch 0x100. Separately, ack withheld 16 cycles -> bus_err_o pulse, imem_req low 1 cycle, then fetch 0x100.
- Reset with RESET_VEC=32'hFFFF_FFFC -> fetch FFFF_FFFC then 0000_0000. Separately, assert rst=0 mid-FETCH -> imem_req=0 immediately, pc=RESET_VEC.
